// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered ALU-control decode stage with one-entry skid buffer
module alu_ctrl_stage #(
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [CNT_WIDTH-1:0]     illegal_count
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_XOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_BEQ = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1010;

    logic [3:0]               dec_code;
    logic                     dec_ill;
    logic [OPCODE_LENGTH-1:0] dec_op;

    logic                     out_v;
    logic [OPCODE_LENGTH-1:0] out_op;
    logic                     out_ill;
    logic                     skid_v;
    logic [OPCODE_LENGTH-1:0] skid_op;
    logic                     skid_ill;
    logic                     in_ready_r;
    logic [CNT_WIDTH-1:0]     cnt;

    logic                     accept;
    logic                     consume;

    // Illegal encodings leave dec_code at zero so the ALU sees a harmless AND.
    always_comb begin
        dec_code = 4'b0000;
        dec_ill  = 1'b0;
        case (opcode)
            7'b0110011: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      dec_code = ALU_ADD;
                        else if (funct7 == 7'b0100000) dec_code = ALU_SUB;
                        else                           dec_ill  = 1'b1;
                    end
                    3'b111:  if (funct7 == 7'd0) dec_code = ALU_AND; else dec_ill = 1'b1;
                    3'b110:  if (funct7 == 7'd0) dec_code = ALU_OR;  else dec_ill = 1'b1;
                    3'b100:  if (funct7 == 7'd0) dec_code = ALU_XOR; else dec_ill = 1'b1;
                    3'b001:  if (funct7 == 7'd0) dec_code = ALU_SLL; else dec_ill = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                case (funct3)
                    3'b000:  dec_code = ALU_ADD;
                    3'b111:  dec_code = ALU_AND;
                    3'b110:  dec_code = ALU_OR;
                    3'b100:  dec_code = ALU_XOR;
                    3'b001:  if (funct7 == 7'd0) dec_code = ALU_SLL; else dec_ill = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111: dec_code = ALU_ADD;
            7'b1100011: if (funct3 == 3'b000) dec_code = ALU_BEQ; else dec_ill = 1'b1;
            7'b0110111: dec_code = ALU_LUI;
            default:    dec_ill = 1'b1;
        endcase
    end

    assign dec_op  = OPCODE_LENGTH'(dec_code);
    assign accept  = in_valid && in_ready_r;
    assign consume = out_v && out_ready;

    // in_ready_r always equals "skid empty"; an accept therefore never meets a full skid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v      <= 1'b0;
            out_op     <= '0;
            out_ill    <= 1'b0;
            skid_v     <= 1'b0;
            skid_op    <= '0;
            skid_ill   <= 1'b0;
            in_ready_r <= 1'b1;
            cnt        <= '0;
        end else if (flush) begin
            out_v      <= 1'b0;
            skid_v     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            if (accept) begin
                if (!out_v || out_ready) begin
                    out_v   <= 1'b1;
                    out_op  <= dec_op;
                    out_ill <= dec_ill;
                end else begin
                    skid_v     <= 1'b1;
                    skid_op    <= dec_op;
                    skid_ill   <= dec_ill;
                    in_ready_r <= 1'b0;
                end
                if (dec_ill && (cnt != '1)) cnt <= cnt + 1'b1;
            end else if (consume) begin
                if (skid_v) begin
                    out_op     <= skid_op;
                    out_ill    <= skid_ill;
                    skid_v     <= 1'b0;
                    in_ready_r <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_v;
    assign Operation     = out_op;
    assign illegal       = out_ill;
    assign illegal_count = cnt;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - scoreboard bench for alu_ctrl_stage with reference decode model
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;

    logic        in_ready, out_valid, illegal;
    logic [3:0]  Operation;
    logic [15:0] illegal_count;
    logic        in_ready2, out_valid2, illegal2;
    logic [3:0]  operation2;
    logic [1:0]  illegal_count2;

    always #5 clk = ~clk;

    alu_ctrl_stage #(.OPCODE_LENGTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
        .out_ready(out_ready), .Operation(Operation), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    alu_ctrl_stage #(.OPCODE_LENGTH(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid2),
        .out_ready(out_ready), .Operation(operation2), .illegal(illegal2),
        .illegal_count(illegal_count2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] q[$];
    int mon_occ = 0;
    bit mon_en = 1'b0;
    int exp_cnt = 0;
    int exp_cnt2 = 0;

    logic [6:0] t_opc[11] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
    logic [2:0] t_f3[11]  = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0};
    logic [6:0] t_f7[11]  = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {illegal, operation}; op code -1 marks an unsupported encoding.
    function automatic logic [4:0] ref_decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        int op;
        int f3i;
        op  = -1;
        f3i = int'(f3);
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                if (f3i == 0) op = 4;
                else if (f3i == 7) op = 0;
                else if (f3i == 6) op = 3;
                else if (f3i == 4) op = 1;
                else if (f3i == 1) op = 9;
            end else if (f7 == 7'h20 && f3i == 0) begin
                op = 2;
            end
        end else if (opc == 7'h13) begin
            if (f3i == 0) op = 4;
            else if (f3i == 7) op = 0;
            else if (f3i == 6) op = 3;
            else if (f3i == 4) op = 1;
            else if (f3i == 1 && f7 == 7'h00) op = 9;
        end else if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67) begin
            op = 4;
        end else if (opc == 7'h63 && f3i == 0) begin
            op = 8;
        end else if (opc == 7'h37) begin
            op = 10;
        end
        if (op < 0) return 5'b1_0000;
        return {1'b0, 4'(op)};
    endfunction

    always @(negedge clk) begin
        logic [4:0] e;
        mon_occ = q.size();
        if (mon_en) begin
            check("out_valid", int'(out_valid), int'(q.size() > 0));
            check("in_ready", int'(in_ready), int'(q.size() < 2));
            check("illegal_count", int'(illegal_count), exp_cnt);
            check("illegal_count_sat", int'(illegal_count2), exp_cnt2);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("scoreboard_underflow", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("Operation", int'(Operation), int'(e[3:0]));
                    check("illegal", int'(illegal), int'(e[4]));
                end
            end
        end
    end

    task automatic step(input bit v, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input bit ordy, input bit fl, input bit rst);
        logic [4:0] e;
        in_valid  = v;
        opcode    = opc;
        funct3    = f3;
        funct7    = f7;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else if (fl) begin
            q.delete();
        end else if (v && mon_occ < 2) begin
            e = ref_decode(opc, f3, f7);
            q.push_back(e);
            if (e[4]) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        bit fl, rst;
        logic [6:0] ro, r7;
        logic [2:0] r3;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        mon_en = 1'b1;
        check("reset_Operation", int'(Operation), 0);
        check("reset_illegal", int'(illegal), 0);

        for (int i = 0; i < 11; i++) step(1, t_opc[i], t_f3[i], t_f7[i], 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 6; i++) step(1, t_opc[i], t_f3[i], t_f7[i], (i < 2), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);

        step(1, 7'h33, 3'd0, 7'h01, 1, 0, 0);
        step(1, 7'h63, 3'd1, 7'h00, 1, 0, 0);
        step(1, 7'h7F, 3'd0, 7'h00, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 7'h7F, 3'd3, 7'h05, 1, 0, 0);
        step(1, 7'h13, 3'd5, 7'h00, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 3; i++) step(1, t_opc[i], t_f3[i], t_f7[i], 0, 0, 0);
        step(1, 7'h7F, 3'd0, 7'h00, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            k   = $urandom_range(0, 15);
            rst = ($urandom_range(0, 499) == 0);
            fl  = !rst && ($urandom_range(0, 39) == 0);
            if (k < 11) begin
                ro = t_opc[k];
                r3 = t_f3[k];
                r7 = t_f7[k];
            end else begin
                ro = (k < 14) ? t_opc[$urandom_range(0, 10)] : 7'($urandom);
                r3 = 3'($urandom);
                r7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom);
            end
            step($urandom_range(0, 3) != 0, ro, r3, r7,
                 !(fl || rst) && ($urandom_range(0, 2) != 0), fl, rst);
        end

        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
        check("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
